fp32_mul_sched: RTL

Shares one FP32 multiplier instance among N requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin, one issue per cycle. Each result is routed back to its requester through a tag pipeline that matches the multiplier latency. The block sits between the datapath clients and the multiplier, and drives the multiplier's two operand inputs.

---
 rtl/fp32_mul_pkg.sv | 19 +
 rtl/fp32_mul_sched_rr_arbiter.sv | 41 ++++
 rtl/fp32_mul_sched.sv | 115 +++++++++++
 3 files changed

// File: rtl/fp32_mul_pkg.sv
// Shared types and constants for the FP32 multiplier scheduler.
// Tag indices are sized for up to 8 requesters.
package fp32_mul_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP32_ONE   = 32'h3F800000;
    localparam fp32_t FP32_TWO   = 32'h40000000;
    localparam fp32_t FP32_THREE = 32'h40400000;
    localparam fp32_t FP32_SIX   = 32'h40C00000;

    localparam int IDX_W = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/fp32_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request above i_ptr,
// wrapping to the lowest request when nothing above the pointer is asking.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic          w_hi_found;
    logic          w_lo_found;
    logic [IW-1:0] w_hi_idx;
    logic [IW-1:0] w_lo_idx;

    // Descending scan leaves the lowest matching index in each candidate.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IW'(j);
                if (IW'(j) > i_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IW'(j);
                end
            end
        end
    end

    assign o_any   = w_lo_found;
    assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
    assign o_grant = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/fp32_mul_sched.sv
// Shares one pipelined FP32 multiplier among N requesters: round-robin issue,
// a tag pipeline matched to the multiplier latency, and one result slot each.
module fp32_mul_sched
    import fp32_mul_pkg::*;
#(
    parameter int N       = 4,
    parameter int MUL_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N-1:0]      i_req_valid,
    output logic [N-1:0]      o_req_ready,
    input  logic [N*32-1:0]   i_req_a,
    input  logic [N*32-1:0]   i_req_b,
    output logic [N-1:0]      o_rsp_valid,
    input  logic [N-1:0]      i_rsp_ready,
    output logic [N*32-1:0]   o_rsp_data,
    output logic [31:0]       o_mul_a,
    output logic [31:0]       o_mul_b,
    input  logic [31:0]       i_mul_product,
    output logic              o_busy
);

    localparam int DEPTH = MUL_LAT + 1;

    logic [IDX_W-1:0] r_ptr;
    tag_t             r_tag [DEPTH];
    logic [N-1:0]     r_inflight;
    logic [N-1:0]     r_rsp_valid;
    logic [N*32-1:0]  r_rsp_data;
    fp32_t            r_mul_a;
    fp32_t            r_mul_b;

    logic [N-1:0]     w_elig;
    logic [N-1:0]     w_grant;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    fp32_t            w_sel_a;
    fp32_t            w_sel_b;
    tag_t             w_done;

    // A requester with anything outstanding waits, so its slot never overflows.
    assign w_elig = i_req_valid & ~r_inflight & ~r_rsp_valid;

    rr_arbiter #(
        .N  (N),
        .IW (IDX_W)
    ) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_sel_a = i_req_a[i*32 +: 32];
                w_sel_b = i_req_b[i*32 +: 32];
            end
        end
    end

    assign w_done = r_tag[DEPTH-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= IDX_W'(N - 1);
            r_inflight  <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            if (w_any) begin
                r_ptr   <= w_idx;
                r_mul_a <= w_sel_a;
                r_mul_b <= w_sel_b;
            end
            r_tag[0] <= '{valid: w_any, idx: w_idx};
            for (int k = 1; k < DEPTH; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            // The final tag stage lines up with the product on i_mul_product.
            for (int i = 0; i < N; i++) begin
                if (w_done.valid && (w_done.idx == IDX_W'(i))) begin
                    r_rsp_data[i*32 +: 32] <= i_mul_product;
                    r_rsp_valid[i]         <= 1'b1;
                    r_inflight[i]          <= 1'b0;
                end else begin
                    if (i_rsp_ready[i] && r_rsp_valid[i]) begin
                        r_rsp_valid[i] <= 1'b0;
                    end
                    if (w_grant[i]) begin
                        r_inflight[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_req_ready = w_grant;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
    assign o_busy      = (|r_inflight) | (|r_rsp_valid);

endmodule
